// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit.
// Op encodings, FSM states and op-class helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic logic op_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv bundle: start/op/operands, MTHI/MTLO
// writes, and busy/done/div_by_zero/hi/lo back to the pipeline.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate.
// Ports: neg (negate when 1), x (in), y (out), all W bits wide.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Ports: clk, rst_n (sync, active low), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic               neg_q;
  logic               neg_r;
  logic               dz_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_out;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign sgn = op_signed(bus.op);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (
    .neg (sgn & bus.a[WIDTH-1]),
    .x   (bus.a),
    .y   (a_mag)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (
    .neg (sgn & bus.b[WIDTH-1]),
    .x   (bus.b),
    .y   (b_mag)
  );

  // Multiply: {acc, shreg} is the product register,
  // multiplier in shreg shifted out LSB first.
  assign addend  = shreg[0] ? opnd : '0;
  assign mul_sum = {1'b0, acc} + {1'b0, addend};

  // Divide: acc is the remainder, shreg shifts the dividend
  // out and the quotient in; the trial needs one extra bit.
  assign div_shift = {acc, shreg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .neg (neg_q),
    .x   ({acc, shreg}),
    .y   (prod)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .neg (neg_q),
    .x   (shreg),
    .y   (quo)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg (neg_r),
    .x   (acc),
    .y   (rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      acc    <= '0;
      shreg  <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_out <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            div_q  <= op_div(bus.op);
            neg_q  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= sgn & bus.a[WIDTH-1];
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH-1);
            busy_q <= 1'b1;
            if (op_div(bus.op)) begin
              shreg <= a_mag;
              opnd  <= b_mag;
            end else begin
              shreg <= b_mag;
              opnd  <= a_mag;
            end
            if (op_div(bus.op) && (bus.b == '0)) begin
              dz_q  <= 1'b1;
              state <= FINISH;
            end else begin
              dz_q  <= 1'b0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (div_q) begin
            if (!div_diff[WIDTH]) begin
              acc   <= div_diff[WIDTH-1:0];
              shreg <= {shreg[WIDTH-2:0], 1'b1};
            end else begin
              acc   <= div_shift[WIDTH-1:0];
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc   <= mul_sum[WIDTH:1];
            shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FINISH: begin
          if (!dz_q) begin
            if (div_q) begin
              lo_q <= quo;
              hi_q <= rem;
            end else begin
              {hi_q, lo_q} <= prod;
            end
          end
          done_q <= 1'b1;
          dz_out <= dz_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32).
// Inputs driven and outputs sampled on the falling edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a falling edge; returns one falling edge later,
  // after the accept edge has passed.
  task automatic start_op(input op_e op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
  endtask

  // n counts falling edges after the accept edge until done.
  task automatic wait_done(output int n, output int bcnt);
    n    = 0;
    bcnt = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errs++;
      $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.div_by_zero !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b%b%b expected 000",
               bus.busy, bus.done, bus.div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int n, bc;
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, bc);
    chk("multu_latency", n, 33);
    chk("multu_busy_cycles", bc, 33);
    chk("multu_busy_in_done", {31'b0, bus.busy}, 0);
    chk("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_lo", bus.lo, 32'h00000001);
    chk("multu_dz", {31'b0, bus.div_by_zero}, 0);
    @(negedge clk);
    chk("multu_done_pulse", {31'b0, bus.done}, 0);
  endtask

  task automatic test_mult;
    int n, bc;
    start_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(n, bc);
    chk("mult_latency", n, 33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);
    @(negedge clk);
  endtask

  task automatic test_div;
    int n, bc;
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n, bc);
    chk("div_latency", n, 33);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done(n, bc);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    @(negedge clk);
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, bc);
    chk("divmin_lo", bus.lo, 32'h80000000);
    chk("divmin_hi", bus.hi, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int n, bc;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'h1234);
    start_op(OP_DIVU, 32'd100, 32'd0);
    wait_done(n, bc);
    chk("dz_latency", n, 1);
    chk("dz_flag", {31'b0, bus.div_by_zero}, 1);
    chk("dz_hi", bus.hi, 32'h1234);
    chk("dz_lo", bus.lo, 32'h80000000);
    @(negedge clk);
    chk("dz_flag_clear", {31'b0, bus.div_by_zero}, 0);
  endtask

  task automatic test_mt_both;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mt_both_hi", bus.hi, 32'hA5A5_0F0F);
    chk("mt_both_lo", bus.lo, 32'hA5A5_0F0F);
  endtask

  task automatic test_busy_ignore;
    int n, bc;
    start_op(OP_MULTU, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd3;
    bus.b     = 32'd0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("busy_mthi_dropped", bus.hi, 32'hA5A5_0F0F);
    wait_done(n, bc);
    chk("ignore_latency", n, 27);
    chk("ignore_hi", bus.hi, 32'h0);
    chk("ignore_lo", bus.lo, 32'd42);
    chk("ignore_dz", {31'b0, bus.div_by_zero}, 0);
  endtask

  task automatic test_back_to_back;
    int n, bc;
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done(n, bc);
    chk("b2b_first_lo", bus.lo, 32'd14);
    start_op(OP_MULTU, 32'd5, 32'd5);
    chk("b2b_busy", {31'b0, bus.busy}, 1);
    wait_done(n, bc);
    chk("b2b_latency", n, 33);
    chk("b2b_lo", bus.lo, 32'd25);
    chk("b2b_hi", bus.hi, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmid_busy", {31'b0, bus.busy}, 0);
    chk("rmid_done", {31'b0, bus.done}, 0);
    chk("rmid_hi", bus.hi, 32'h0);
    chk("rmid_lo", bus.lo, 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("rmid_no_done", seen, 0);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'h0;
    @(negedge clk);
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_mt_both;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
